// File: rtl/rvx_chain_req_initiator_if.sv
// ----------------------------------------------------------------------------
// rvx_chain_req_initiator_if
// Bundles the handshake/bus signals of the chain request initiator.
//   cmd_*      local command in        (valid/ready, id, payload)
//   rsp_*      local result out        (valid/ready, data, status)
//   tx_*       request packet to chain (valid/ready, {type, body})
//   rx_*       packet from chain       (valid/ready, {type, body})
//   stray_drop one-cycle pulse when an rx packet is discarded
//   busy       initiator is not idle
// Modports: master = initiator side, slave = environment side.
// ----------------------------------------------------------------------------
interface rvx_chain_req_initiator_if #(
  parameter int TYPE_W = 2,
  parameter int BODY_W = 8,
  parameter int ID_W   = 2
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ID_W-1:0]          cmd_id;
  logic [BODY_W-ID_W-1:0]   cmd_payload;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [BODY_W-1:0]        rsp_data;
  logic [1:0]               rsp_status;

  logic                     tx_valid;
  logic                     tx_ready;
  logic [TYPE_W+BODY_W-1:0] tx_packet;

  logic                     rx_valid;
  logic                     rx_ready;
  logic [TYPE_W+BODY_W-1:0] rx_packet;

  logic                     stray_drop;
  logic                     busy;

  modport master (
    input  cmd_valid, cmd_id, cmd_payload, rsp_ready, tx_ready, rx_valid, rx_packet,
    output cmd_ready, rsp_valid, rsp_data, rsp_status, tx_valid, tx_packet, rx_ready,
           stray_drop, busy
  );

  modport slave (
    output cmd_valid, cmd_id, cmd_payload, rsp_ready, tx_ready, rx_valid, rx_packet,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status, tx_valid, tx_packet, rx_ready,
           stray_drop, busy
  );
endinterface

// File: rtl/rvx_chain_req_initiator.sv
// ----------------------------------------------------------------------------
// rvx_chain_req_initiator
// Initiator end of the single-word request/response packet chain. One local
// command becomes one request packet on tx; the initiator then waits on rx for
// either a response or its own request coming back unclaimed, and returns the
// result locally with a status. One transaction outstanding at a time.
// Ports:
//   clk    clock, rising edge
//   rstnn  asynchronous reset, active low
//   bus    rvx_chain_req_initiator_if.master (cmd, rsp, tx, rx, stray_drop, busy)
// Status codes: 00 ok, 01 unclaimed, 10 timeout.
// ----------------------------------------------------------------------------
module rvx_chain_req_initiator #(
  parameter int TYPE_W    = 2,
  parameter int BODY_W    = 8,
  parameter int ID_W      = 2,
  parameter int TYPE_REQ  = 1,
  parameter int TYPE_RSP  = 2,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic                         clk,
  input  logic                         rstnn,
  rvx_chain_req_initiator_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {
    STAT_OK        = 2'b00,
    STAT_UNCLAIMED = 2'b01,
    STAT_TIMEOUT   = 2'b10
  } status_t;

  localparam logic [TYPE_W-1:0]    TYPE_REQ_C = TYPE_W'(TYPE_REQ);
  localparam logic [TYPE_W-1:0]    TYPE_RSP_C = TYPE_W'(TYPE_RSP);
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t                r_state,      w_state_nxt;
  logic [BODY_W-1:0]     r_body,       w_body_nxt;
  logic [TIMEOUT_W-1:0]  r_timer,      w_timer_nxt;
  logic [BODY_W-1:0]     r_rsp_data,   w_rsp_data_nxt;
  status_t               r_rsp_status, w_rsp_status_nxt;
  logic                  r_stray,      w_stray_nxt;

  logic                  w_rx_ready;
  logic                  w_rx_fire;
  logic [TYPE_W-1:0]     w_rx_type;
  logic [BODY_W-1:0]     w_rx_body;
  logic                  w_rx_is_rsp;
  logic                  w_rx_is_own;
  logic                  w_timeout;

  // Handshake outputs decode from state only: no ready->valid combinational path.
  assign w_rx_ready  = (r_state != S_DONE);
  assign w_rx_fire   = bus.rx_valid && w_rx_ready;
  assign w_rx_type   = bus.rx_packet[TYPE_W+BODY_W-1 -: TYPE_W];
  assign w_rx_body   = bus.rx_packet[BODY_W-1:0];
  assign w_rx_is_rsp = (w_rx_type == TYPE_RSP_C);
  // Our own request came round the ring without any responder claiming it.
  assign w_rx_is_own = (w_rx_type == TYPE_REQ_C) &&
                       (w_rx_body[BODY_W-1 -: ID_W] == r_body[BODY_W-1 -: ID_W]);
  assign w_timeout   = (TIMEOUT != 0) && (r_timer == TIMER_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_body_nxt       = r_body;
    w_timer_nxt      = r_timer;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_status_nxt = r_rsp_status;
    w_stray_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_stray_nxt = w_rx_fire;
        if (bus.cmd_valid) begin
          w_body_nxt  = {bus.cmd_id, bus.cmd_payload};
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_stray_nxt = w_rx_fire;
        if (bus.tx_ready) begin
          w_timer_nxt = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_rx_fire && w_rx_is_rsp) begin
          w_rsp_data_nxt   = w_rx_body;
          w_rsp_status_nxt = STAT_OK;
          w_state_nxt      = S_DONE;
        end else if (w_rx_fire && w_rx_is_own) begin
          w_rsp_data_nxt   = w_rx_body;
          w_rsp_status_nxt = STAT_UNCLAIMED;
          w_state_nxt      = S_DONE;
        end else begin
          // A real rx result has priority over a timeout in the same cycle.
          w_stray_nxt = w_rx_fire;
          if (w_timeout) begin
            w_rsp_data_nxt   = '0;
            w_rsp_status_nxt = STAT_TIMEOUT;
            w_state_nxt      = S_DONE;
          end else begin
            w_timer_nxt = r_timer + TIMEOUT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the data/status registers are reset too, so outputs are defined (0)
  // straight out of reset instead of showing stale values.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_body       <= '0;
      r_timer      <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= STAT_OK;
      r_stray      <= 1'b0;
    end else begin
      r_body       <= w_body_nxt;
      r_timer      <= w_timer_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_stray      <= w_stray_nxt;
    end
  end

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.tx_valid   = (r_state == S_SEND);
  assign bus.tx_packet  = (r_state == S_SEND) ? {TYPE_REQ_C, r_body} : '0;
  assign bus.rx_ready   = w_rx_ready;
  assign bus.rsp_valid  = (r_state == S_DONE);
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_status = r_rsp_status;
  assign bus.stray_drop = r_stray;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rvx_chain_req_initiator.sv
// ----------------------------------------------------------------------------
// tb_rvx_chain_req_initiator
// Directed bench for rvx_chain_req_initiator (TIMEOUT=16). Inputs are driven
// and outputs sampled just after the falling edge, half a period away from
// the active rising edge.
// ----------------------------------------------------------------------------
module tb_rvx_chain_req_initiator;

  logic clk   = 1'b0;
  logic rstnn = 1'b0;
  int   n_asserts = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  rvx_chain_req_initiator_if #(.TYPE_W(2), .BODY_W(8), .ID_W(2)) bus ();

  rvx_chain_req_initiator #(
    .TYPE_W(2), .BODY_W(8), .ID_W(2), .TYPE_REQ(1), .TYPE_RSP(2),
    .TIMEOUT(16), .TIMEOUT_W(8)
  ) dut (
    .clk   (clk),
    .rstnn (rstnn),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a command for one cycle (accepted in IDLE).
  task automatic do_cmd(input logic [1:0] id, input logic [5:0] pay);
    bus.cmd_valid   = 1'b1;
    bus.cmd_id      = id;
    bus.cmd_payload = pay;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic do_tx();
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
  endtask

  task automatic do_rx(input logic [9:0] pkt);
    bus.rx_valid  = 1'b1;
    bus.rx_packet = pkt;
    tick();
    bus.rx_valid  = 1'b0;
  endtask

  task automatic do_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  // {cmd_ready, rx_ready, tx_valid, rsp_valid, busy, stray_drop}
  function automatic logic [5:0] flags();
    return {bus.cmd_ready, bus.rx_ready, bus.tx_valid, bus.rsp_valid, bus.busy, bus.stray_drop};
  endfunction

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_id = '0; bus.cmd_payload = '0;
    bus.rsp_ready = 1'b0; bus.tx_ready = 1'b0;
    bus.rx_valid  = 1'b0; bus.rx_packet = '0;

    // Reset state
    tick(); tick();
    check("reset_flags",  32'(flags()), 32'b110000);
    check("reset_txpkt",  32'(bus.tx_packet), 32'h000);
    check("reset_rsp",    32'({bus.rsp_status, bus.rsp_data}), 32'h000);
    rstnn = 1'b1;
    tick();

    // 1: id=2, payload=0x25 -> 0x1A5, held while tx_ready=0; response 0x23C
    do_cmd(2'd2, 6'h25);
    check("t1_send_flags", 32'(flags()), 32'b011010);
    for (int i = 0; i < 3; i++) begin
      check("t1_tx_hold", 32'(bus.tx_packet), 32'h1A5);
      tick();
    end
    check("t1_tx_hold_end", 32'(bus.tx_packet), 32'h1A5);
    do_tx();
    check("t1_wait_flags", 32'(flags()), 32'b010010);
    do_rx(10'h23C);
    check("t1_done_flags", 32'(flags()), 32'b000110);
    check("t1_rsp_data",   32'(bus.rsp_data), 32'h3C);
    check("t1_rsp_status", 32'(bus.rsp_status), 32'h0);
    do_rsp();
    check("t1_idle_flags", 32'(flags()), 32'b110000);

    // 2: own request returns unclaimed
    do_cmd(2'd2, 6'h25);
    do_tx();
    do_rx(10'h1A5);
    check("t2_rsp_status", 32'(bus.rsp_status), 32'h1);
    check("t2_rsp_data",   32'(bus.rsp_data), 32'hA5);
    check("t2_no_stray",   32'(bus.stray_drop), 32'h0);
    do_rsp();

    // 4a: timeout; tx accept cycle is cycle 0, rsp_valid first seen in cycle 17
    do_cmd(2'd1, 6'h03);
    check("t4_tx_pkt", 32'(bus.tx_packet), 32'h143);
    do_tx();                 // now cycle 1
    repeat (15) tick();      // now cycle 16
    check("t4_c16_no_rsp", 32'(bus.rsp_valid), 32'h0);
    tick();                  // cycle 17
    check("t4_c17_rsp",    32'(bus.rsp_valid), 32'h1);
    check("t4_status",     32'(bus.rsp_status), 32'h2);
    check("t4_data",       32'(bus.rsp_data), 32'h00);
    do_rsp();

    // 4b: response on the timeout cycle wins
    do_cmd(2'd1, 6'h03);
    do_tx();                 // cycle 1
    repeat (15) tick();      // cycle 16 (timer at its last value)
    do_rx(10'h2C3);
    check("t4b_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t4b_status",    32'(bus.rsp_status), 32'h0);
    check("t4b_data",      32'(bus.rsp_data), 32'hC3);
    do_rsp();

    // 3: stray packets in WAIT, then response 0x200
    do_cmd(2'd2, 6'h15);
    check("t3_tx_pkt", 32'(bus.tx_packet), 32'h195);
    do_tx();
    do_rx(10'h3FF);
    check("t3_stray1", 32'({bus.stray_drop, bus.rsp_valid}), 32'b10);
    do_rx(10'h1C0);
    check("t3_stray2", 32'({bus.stray_drop, bus.rsp_valid}), 32'b10);
    tick();
    check("t3_stray_pulse_end", 32'(bus.stray_drop), 32'h0);
    do_rx(10'h200);
    check("t3_rsp", 32'({bus.rsp_valid, bus.rsp_status, bus.rsp_data}), {21'd0, 1'b1, 2'b00, 8'h00});
    do_rsp();

    // 5: hold DONE with backpressure on both sides
    do_cmd(2'd3, 6'h01);
    do_tx();
    do_rx(10'h277);
    bus.rx_valid  = 1'b1;
    bus.rx_packet = 10'h3FF;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold", 32'({flags(), bus.rsp_status, bus.rsp_data}), {16'd0, 6'b000110, 2'b00, 8'h77});
      tick();
    end
    bus.rx_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_id    = 2'd0;
    bus.cmd_payload = 6'h2A;
    tick();
    bus.rsp_ready = 1'b0;
    check("t5_idle_no_accept", 32'(flags()), 32'b110000);
    tick();
    bus.cmd_valid = 1'b0;
    check("t5_next_cmd", 32'({bus.tx_valid, bus.tx_packet}), {21'd0, 1'b1, 10'h12A});

    // 6: asynchronous reset during SEND
    #2 rstnn = 1'b0;
    #1;
    check("t6_send_rst_flags", 32'(flags()), 32'b110000);
    check("t6_send_rst_data",  32'({bus.tx_packet, bus.rsp_status, bus.rsp_data}), 32'h0);
    tick();
    rstnn = 1'b1;
    tick();

    // stray in IDLE
    do_rx(10'h200);
    check("t6_idle_stray", 32'(flags()), 32'b110001);

    // asynchronous reset during WAIT, right after a stray pulse
    do_cmd(2'd1, 6'h11);
    do_tx();
    do_rx(10'h3FF);
    check("t6_wait_stray", 32'(flags()), 32'b010011);
    #2 rstnn = 1'b0;
    #1;
    check("t6_wait_rst_flags", 32'(flags()), 32'b110000);
    tick();
    rstnn = 1'b1;
    tick();

    // normal transaction after reset
    do_cmd(2'd3, 6'h2A);
    check("t6_tx_pkt", 32'(bus.tx_packet), 32'h1EA);
    do_tx();
    do_rx(10'h281);
    check("t6_rsp", 32'({bus.rsp_valid, bus.rsp_status, bus.rsp_data}), {21'd0, 1'b1, 2'b00, 8'h81});
    do_rsp();
    check("t6_final_idle", 32'(flags()), 32'b110000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
